pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 id_rs1_addr_i / id_rs2_addr_i  in  5 each  source register addresses of the instruction in ID.
REQ-004 id_rs1_used_i / id_rs2_used_i  in  1 each  ID instruction reads rs1 / rs2.
REQ-005 ex_rd_addr_i  in  5  destination register of the instruction in EX (addr_rd_o of ID/EX).
REQ-006 ex_load_i  in  1  instruction in EX is a load (load_code_o of ID/EX is not LOAD_NOPE).
REQ-007 br_taken_i  in  1  EX resolved a taken branch or jump this cycle.
REQ-008 mem_req_i / mem_ready_i  in  1 each  MEM-stage data access pending / completes this cycle.
REQ-009 pc_hold_n_o, if_id_hold_n_o, id_ex_hold_n_o, ex_mem_hold_n_o  out  1 each  write enables of PC and pipeline registers (1 = advance).
REQ-010 if_id_flush_o / id_ex_flush_o  out  1 each  load a bubble (reset-value NOP) into IF/ID / ID/EX this cycle.
REQ-011 mem_timeout_o  out  1  one-cycle pulse when a MEM access has waited 15 cycles.
REQ-012 stall_cnt_o / flush_cnt_o  out  32 each  performance counters (REQ-027).

Function
REQ-013 FSM states: RUN, MEM_WAIT; outputs are combinational from state and inputs.
REQ-014 Load-use hazard = ex_load_i & ex_rd_addr_i != 0 & ((id_rs1_used_i & rs1 == rd) | (id_rs2_used_i & rs2 == rd)).
REQ-015 Load-use in RUN, no higher priority event: pc_hold_n_o = if_id_hold_n_o = 0, id_ex_flush_o = 1, ex_mem_hold_n_o = 1; exactly one bubble cycle per hazard.
REQ-016 Taken branch in RUN: if_id_flush_o = id_ex_flush_o = 1, all holds 1, for that cycle only.
REQ-017 Priority: MEM stall > taken branch > load-use; branch coincident with load-use yields REQ-016 behaviour only.
REQ-018 RUN -> MEM_WAIT when mem_req_i & !mem_ready_i; in that cycle and all MEM_WAIT cycles, all four hold_n outputs = 0, both flushes = 0.
REQ-019 MEM_WAIT -> RUN on the cycle mem_ready_i = 1; that cycle all holds 1 and branch/load-use evaluated normally.
REQ-020 Wait counter (4 bit) clears on entry to MEM_WAIT, increments each MEM_WAIT cycle, saturates at 15; mem_timeout_o pulses once on reaching 15.
REQ-021 mem_req_i & mem_ready_i in the same RUN cycle: no stall, stays in RUN.
REQ-022 No hazard, no branch, no MEM stall: all holds 1, all flushes 0.

Reset
REQ-023 rst = 1 at a clock edge: state RUN, wait counter 0, both perf counters 0.
REQ-024 While rst = 1: all hold_n outputs 1, flushes 0, mem_timeout_o 0, regardless of inputs.
REQ-025 Reset mid MEM_WAIT abandons the wait; next cycle in RUN with no timeout pulse.

Configuration
REQ-026 Macro PIPE_PERF_CNT_EN selects performance counters.
REQ-027 Defined: stall_cnt_o increments each cycle pc_hold_n_o = 0, flush_cnt_o each cycle if_id_flush_o or id_ex_flush_o = 1; both saturate at 32'hFFFF_FFFF.
REQ-028 Undefined: counters not instantiated, stall_cnt_o and flush_cnt_o tied to ZERO_WORD; all other behaviour identical.

Structure
REQ-029 define.v gains PCTL_RUN / PCTL_MEM_WAIT state encodings and MEM_TIMEOUT_LIMIT (4'd15); reuses HOLD_EN, HOLD_DIS, REG_ADDR_ZERO, ZERO_WORD.
REQ-030 Load-use comparison in one combinational sub-module pipe_hazard_cmp; state, wait counter and perf counters in gnrl_dff instances.

Verification
REQ-031 EX load rd = 5, ID add rs1 = 5 used -> one cycle pc/if_id holds 0, id_ex_flush 1; next cycle all holds 1.
REQ-032 EX load rd = 0, ID rs1 = 0 used -> no stall, no flush.
REQ-033 br_taken_i = 1 with same load-use condition -> if_id_flush = id_ex_flush = 1, pc_hold_n 1, no bubble stall.
REQ-034 mem_req_i = 1, mem_ready_i low 3 cycles then high -> all holds 0 for 3 cycles, 1 on ready cycle, no timeout.
REQ-035 mem_ready_i low 20 cycles -> mem_timeout_o single pulse on 15th MEM_WAIT cycle; assert rst on cycle 18 -> RUN, holds 1.
REQ-036 With PIPE_PERF_CNT_EN, REQ-031 plus REQ-033 sequence -> stall_cnt_o = 1, flush_cnt_o = 2; without macro both read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam logic [0:0] PCTL_RUN      = 1'b0;
  localparam logic [0:0] PCTL_MEM_WAIT = 1'b1;

  localparam logic [3:0]  MEM_TIMEOUT_LIMIT = 4'd15;
  localparam logic        HOLD_EN           = 1'b1;
  localparam logic        HOLD_DIS          = 1'b0;
  localparam logic [4:0]  REG_ADDR_ZERO     = 5'd0;
  localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;

  typedef enum logic [0:0] {
    StRun     = PCTL_RUN,
    StMemWait = PCTL_MEM_WAIT
  } pctl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register control outputs of pipe_ctrl.
// slave = the controller, master = the pipeline datapath driving it.
interface pipe_ctrl_if;
  logic [4:0] id_rs1_addr_i;
  logic [4:0] id_rs2_addr_i;
  logic       id_rs1_used_i;
  logic       id_rs2_used_i;
  logic [4:0] ex_rd_addr_i;
  logic       ex_load_i;
  logic       br_taken_i;
  logic       mem_req_i;
  logic       mem_ready_i;
  logic       pc_hold_n_o;
  logic       if_id_hold_n_o;
  logic       id_ex_hold_n_o;
  logic       ex_mem_hold_n_o;
  logic       if_id_flush_o;
  logic       id_ex_flush_o;
  logic       mem_timeout_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
    output ex_rd_addr_i, ex_load_i, br_taken_i, mem_req_i, mem_ready_i,
    input  pc_hold_n_o, if_id_hold_n_o, id_ex_hold_n_o, ex_mem_hold_n_o,
    input  if_id_flush_o, id_ex_flush_o, mem_timeout_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
    input  ex_rd_addr_i, ex_load_i, br_taken_i, mem_req_i, mem_ready_i,
    output pc_hold_n_o, if_id_hold_n_o, id_ex_hold_n_o, ex_mem_hold_n_o,
    output if_id_flush_o, id_ex_flush_o, mem_timeout_o
  );
endinterface

// File: rtl/gnrl_dff.sv
// Generic register with synchronous active-high reset to a parameterised value.
module gnrl_dff #(
  parameter int unsigned      Width  = 1,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= RstVal;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_hazard_cmp.sv
// Load-use hazard detector: ID reads a register that the load in EX will write.
module pipe_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic [4:0] rd_addr_i,
  input  logic       load_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = rs1_used_i && (rs1_addr_i == rd_addr_i);
  assign rs2_hit    = rs2_used_i && (rs2_addr_i == rd_addr_i);
  // x0 is never written, so a load targeting it cannot create a dependency.
  assign load_use_o = load_i && (rd_addr_i != REG_ADDR_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: MEM-wait stalls, taken-branch flushes, load-use bubbles.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  ctrl,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  pctl_state_e state_q, state_d;
  logic [0:0]  state_raw;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        load_use;
  logic        mem_stall;

  logic pc_hold_n, if_id_hold_n, id_ex_hold_n, ex_mem_hold_n;
  logic if_id_flush, id_ex_flush, mem_timeout;

  pipe_hazard_cmp u_hazard_cmp (
    .rs1_addr_i (ctrl.id_rs1_addr_i),
    .rs2_addr_i (ctrl.id_rs2_addr_i),
    .rs1_used_i (ctrl.id_rs1_used_i),
    .rs2_used_i (ctrl.id_rs2_used_i),
    .rd_addr_i  (ctrl.ex_rd_addr_i),
    .load_i     (ctrl.ex_load_i),
    .load_use_o (load_use)
  );

  // State register.
  gnrl_dff #(
    .Width  (1),
    .RstVal (PCTL_RUN)
  ) u_state_dff (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (state_d),
    .q_o   (state_raw)
  );

  assign state_q = pctl_state_e'(state_raw);

  gnrl_dff #(
    .Width  (4),
    .RstVal (4'd0)
  ) u_wait_cnt_dff (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (wait_cnt_d),
    .q_o   (wait_cnt_q)
  );

  // The stall begins in the RUN cycle that first sees the unfinished access.
  assign mem_stall = (state_q == StRun) ? (ctrl.mem_req_i && !ctrl.mem_ready_i)
                                        : !ctrl.mem_ready_i;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (ctrl.mem_req_i && !ctrl.mem_ready_i) begin
          state_d    = StMemWait;
          wait_cnt_d = 4'd0;
        end
      end
      StMemWait: begin
        if (ctrl.mem_ready_i) begin
          state_d = StRun;
        end
        if (wait_cnt_q != MEM_TIMEOUT_LIMIT) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Output logic; reset forces the pipeline to advance with no bubbles.
  always_comb begin
    pc_hold_n     = HOLD_EN;
    if_id_hold_n  = HOLD_EN;
    id_ex_hold_n  = HOLD_EN;
    ex_mem_hold_n = HOLD_EN;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_timeout   = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        pc_hold_n     = HOLD_DIS;
        if_id_hold_n  = HOLD_DIS;
        id_ex_hold_n  = HOLD_DIS;
        ex_mem_hold_n = HOLD_DIS;
      end else if (ctrl.br_taken_i) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_hold_n    = HOLD_DIS;
        if_id_hold_n = HOLD_DIS;
        id_ex_flush  = 1'b1;
      end
      // The counter passes 14 only once per wait, giving a single-cycle pulse.
      mem_timeout = (state_q == StMemWait) && (wait_cnt_q == MEM_TIMEOUT_LIMIT - 4'd1);
    end
  end

  assign ctrl.pc_hold_n_o     = pc_hold_n;
  assign ctrl.if_id_hold_n_o  = if_id_hold_n;
  assign ctrl.id_ex_hold_n_o  = id_ex_hold_n;
  assign ctrl.ex_mem_hold_n_o = ex_mem_hold_n;
  assign ctrl.if_id_flush_o   = if_id_flush;
  assign ctrl.id_ex_flush_o   = id_ex_flush;
  assign ctrl.mem_timeout_o   = mem_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_hold_n && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((if_id_flush || id_ex_flush) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  gnrl_dff #(
    .Width  (32),
    .RstVal (ZERO_WORD)
  ) u_stall_cnt_dff (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (stall_cnt_d),
    .q_o   (stall_cnt_q)
  );

  gnrl_dff #(
    .Width  (32),
    .RstVal (ZERO_WORD)
  ) u_flush_cnt_dff (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (flush_cnt_d),
    .q_o   (flush_cnt_q)
  );

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = ZERO_WORD;
  assign flush_cnt_o = ZERO_WORD;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues expected controls, negedge monitor compares.
module tb_pipe_ctrl;

  // Control vector order: {pc, if_id, id_ex, ex_mem holds, if_id_flush, id_ex_flush, timeout}
  localparam logic [6:0] NOM = 7'b1111_000;
  localparam logic [6:0] LU  = 7'b0011_010;
  localparam logic [6:0] BR  = 7'b1111_110;
  localparam logic [6:0] MS  = 7'b0000_000;
  localparam logic [6:0] TO  = 7'b0000_001;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd1;
  localparam logic [31:0] EXP_FLUSH = 32'd2;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic        chk_cnt;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  int          n_cmp;
  int          n_mis;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [6:0]  mon_act;

  pipe_ctrl_if pif ();

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl        (pif),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic r, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic ld, input logic br, input logic req, input logic rdy);
    rst                = r;
    pif.id_rs1_addr_i  = rs1;
    pif.id_rs1_used_i  = u1;
    pif.id_rs2_addr_i  = rs2;
    pif.id_rs2_used_i  = u2;
    pif.ex_rd_addr_i   = rd;
    pif.ex_load_i      = ld;
    pif.br_taken_i     = br;
    pif.mem_req_i      = req;
    pif.mem_ready_i    = rdy;
  endtask

  task automatic push(input string nm, input logic [6:0] ctl, input logic chk,
                      input logic [31:0] st, input logic [31:0] fl);
    exp_t e;
    e.name    = nm;
    e.ctl     = ctl;
    e.chk_cnt = chk;
    e.stall   = st;
    e.flush   = fl;
    exp_q.push_back(e);
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {pif.pc_hold_n_o, pif.if_id_hold_n_o, pif.id_ex_hold_n_o,
                 pif.ex_mem_hold_n_o, pif.if_id_flush_o, pif.id_ex_flush_o,
                 pif.mem_timeout_o};
      n_cmp++;
      if (mon_act !== mon_e.ctl) begin
        n_mis++;
        $display("FAIL %s: ctl got %b expected %b", mon_e.name, mon_act, mon_e.ctl);
      end
      if (mon_e.chk_cnt) begin
        n_cmp++;
        if ((stall_cnt !== mon_e.stall) || (flush_cnt !== mon_e.flush)) begin
          n_mis++;
          $display("FAIL %s_cnt: stall/flush got %0d/%0d expected %0d/%0d", mon_e.name,
                   stall_cnt, flush_cnt, mon_e.stall, mon_e.flush);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset with every hazard source active: outputs stay nominal.
    next_cycle();
    push("rst_hazards", NOM, 1'b0, 32'd0, 32'd0);
    next_cycle();
    push("rst_cnt", NOM, 1'b1, 32'd0, 32'd0);

    next_cycle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("idle_after_rst", NOM, 1'b1, 32'd0, 32'd0);

    // Load rd=5, ID reads rs1=5: one bubble, then the bubble reaches EX.
    next_cycle();
    set_in(1'b0, 5'd5, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    push("load_use_rs1", LU, 1'b0, 32'd0, 32'd0);
    next_cycle();
    set_in(1'b0, 5'd5, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("after_bubble", NOM, 1'b0, 32'd0, 32'd0);

    next_cycle();
    set_in(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push("load_rd_zero", NOM, 1'b0, 32'd0, 32'd0);

    // Branch beats load-use.
    next_cycle();
    set_in(1'b0, 5'd5, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    push("branch_over_lu", BR, 1'b0, 32'd0, 32'd0);

    next_cycle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("perf_cnt", NOM, 1'b1, EXP_STALL, EXP_FLUSH);

    next_cycle();
    set_in(1'b0, 5'd7, 1'b0, 5'd9, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    push("rs1_unused", NOM, 1'b0, 32'd0, 32'd0);
    next_cycle();
    set_in(1'b0, 5'd1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    push("load_use_rs2", LU, 1'b0, 32'd0, 32'd0);

    // MEM stall outranks branch and load-use; 3 stalled cycles then ready.
    next_cycle();
    set_in(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    push("mem_enter", MS, 1'b0, 32'd0, 32'd0);
    next_cycle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("mem_wait1", MS, 1'b0, 32'd0, 32'd0);
    next_cycle();
    push("mem_wait2", MS, 1'b0, 32'd0, 32'd0);
    next_cycle();
    set_in(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    push("mem_ready_lu", LU, 1'b0, 32'd0, 32'd0);
    next_cycle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("back_in_run", NOM, 1'b0, 32'd0, 32'd0);

    next_cycle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    push("req_and_ready", NOM, 1'b0, 32'd0, 32'd0);
    next_cycle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("no_wait_entered", NOM, 1'b0, 32'd0, 32'd0);

    // Long wait: timeout only on the 15th MEM_WAIT cycle, reset on the 18th.
    next_cycle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("long_enter", MS, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 17; k++) begin
      next_cycle();
      push($sformatf("long_wait%0d", k), (k == 15) ? TO : MS, 1'b0, 32'd0, 32'd0);
    end
    next_cycle();
    rst = 1'b1;
    push("long_wait18_rst", NOM, 1'b0, 32'd0, 32'd0);
    next_cycle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("run_after_rst", NOM, 1'b1, 32'd0, 32'd0);

    next_cycle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
